// File: rtl/id_inst_queue_pkg.sv
// id_inst_queue_pkg: default geometry of the IF-to-ID instruction queue
package id_inst_queue_pkg;
   localparam int IQ_DEPTH    = 4;
   localparam int IF_TO_ID_WD = 65;
   localparam int IQ_INST_W   = 32;
   localparam int IQ_ENTRY_W  = IF_TO_ID_WD - 1;
   localparam int IQ_PC_W     = IQ_ENTRY_W - IQ_INST_W;
endpackage

// File: rtl/id_inst_queue.sv
// id_inst_queue: circular FIFO of fetched {pc, inst} pairs feeding the decode stage
module id_inst_queue
   import id_inst_queue_pkg::*;
#(
   parameter int DEPTH  = IQ_DEPTH,
   parameter int PC_W   = IQ_PC_W,
   parameter int INST_W = IQ_INST_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       in_valid,
   input  logic [PC_W-1:0]            in_pc,
   input  logic [INST_W-1:0]          in_inst,
   output logic                       in_ready,
   output logic                       out_valid,
   output logic [PC_W-1:0]            out_pc,
   output logic [INST_W-1:0]          out_inst,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   logic [PC_W+INST_W-1:0] mem [DEPTH];
   logic [PC_W+INST_W-1:0] head;
   logic [AW-1:0]          rd_ptr, wr_ptr;
   logic                   push, pop;
   assign in_ready  = count != CW'(DEPTH);
   assign out_valid = count != '0;
   assign push      = in_valid & in_ready & ~flush;
   assign pop       = out_valid & out_ready & ~flush;
   assign head      = mem[rd_ptr];
   assign out_pc    = out_valid ? head[PC_W+INST_W-1:INST_W] : '0;
   assign out_inst  = out_valid ? head[INST_W-1:0] : '0;
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
         wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
         count  <= count + CW'(push) - CW'(pop);
      end
   end
   // storage carries no reset; out_* are masked while empty
   always_ff @(posedge clk) begin
      if (push && !rst) mem[wr_ptr] <= {in_pc, in_inst};
   end
endmodule

// File: tb/tb_id_inst_queue.sv
// tb_id_inst_queue: randomized scoreboard bench for id_inst_queue
module tb_id_inst_queue;
   localparam int DEPTH = 4;
   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;
   logic        clk = 0;
   logic        rst = 1;
   logic        flush = 0;
   logic        in_valid = 0;
   logic [31:0] in_pc = 0;
   logic [31:0] in_inst = 0;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic        out_ready = 0;
   logic [2:0]  count;
   int          checks = 0;
   int          errors = 0;
   bit          en = 0;
   ent_t        sb[$];
   id_inst_queue #(.DEPTH(DEPTH), .PC_W(32), .INST_W(32)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_pc(in_pc),
      .in_inst(in_inst), .in_ready(in_ready), .out_valid(out_valid), .out_pc(out_pc),
      .out_inst(out_inst), .out_ready(out_ready), .count(count)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask
   // reference: the queue contents themselves; occupancy is sb.size()
   always @(negedge clk) begin
      if (en) begin
         chk("count", 64'(count), 64'(sb.size()));
         chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
         chk("in_ready", 64'(in_ready), 64'(sb.size() != DEPTH));
         chk("out_pc", 64'(out_pc), sb.size() != 0 ? 64'(sb[0].pc) : 64'(0));
         chk("out_inst", 64'(out_inst), sb.size() != 0 ? 64'(sb[0].inst) : 64'(0));
      end
      if (rst || flush) sb.delete();
      else begin
         automatic bit do_pop  = sb.size() != 0 && out_ready;
         automatic bit do_push = in_valid && sb.size() != DEPTH;
         if (do_pop) void'(sb.pop_front());
         if (do_push) sb.push_back('{pc: in_pc, inst: in_inst});
      end
   end
   task automatic step(input bit r, input bit f, input bit iv, input logic [31:0] pc,
                       input logic [31:0] inst, input bit ordy);
      @(posedge clk);
      #1;
      rst = r; flush = f; in_valid = iv; in_pc = pc; in_inst = inst; out_ready = ordy;
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
   endtask
   initial begin
      @(posedge clk);
      #1;
      en = 1;
      step(1, 0, 0, 0, 0, 0);
      step(0, 0, 1, 32'hBFC0_0000, 32'h3C01_1234, 0);
      idle(2);
      step(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 1, 32'h1000 + 4 * i, 32'hA000 + i, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1);
      idle(1);
      step(0, 0, 1, 32'h2000, 32'hB000, 0);
      step(0, 0, 1, 32'h2004, 32'hB001, 0);
      for (int i = 0; i < 10; i++) step(0, 0, 1, 32'h2008 + 4 * i, 32'hB002 + i, 1);
      step(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 32'h3000 + 4 * i, 32'hC000 + i, 0);
      step(0, 1, 1, 32'hDEAD_BEEF, 32'hFEED_F00D, 0);
      idle(2);
      step(0, 0, 1, 32'h4000, 32'hD000, 0);
      idle(3);
      step(1, 0, 0, 0, 0, 0);
      idle(2);
      for (int i = 0; i < 2000; i++)
         step($urandom_range(199) == 0, $urandom_range(19) == 0, $urandom_range(9) < 7,
              $urandom, $urandom, $urandom_range(9) < 6);
      idle(2);
      for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 0, 0, 0, 1);
      @(posedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/id_inst_queue.md
ID_INST_QUEUE -- requirements
Module: id_inst_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, entry count; power of two, 2..16.
REQ-002 SHALL have parameter PC_W, default 32, PC field width.
REQ-003 SHALL have parameter INST_W, default 32, instruction field width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port flush  input  1  discard all entries (branch redirect/exception).
REQ-007 SHALL have port in_valid  input  1  IF presents an entry.
REQ-008 SHALL have port in_pc  input  PC_W  PC of the pushed entry.
REQ-009 SHALL have port in_inst  input  INST_W  instruction of the pushed entry.
REQ-010 SHALL have port in_ready  output  1  queue accepts a push this cycle.
REQ-011 SHALL have port out_valid  output  1  head entry valid toward ID.
REQ-012 SHALL have port out_pc  output  PC_W  head PC.
REQ-013 SHALL have port out_inst  output  INST_W  head instruction.
REQ-014 SHALL have port out_ready  input  1  ID consumes head this cycle (low while ID stalls).
REQ-015 SHALL have port count  output  $clog2(DEPTH+1)  current occupancy.

Function
REQ-016 Push SHALL occur iff in_valid & in_ready & ~flush; pop SHALL occur iff out_valid & out_ready & ~flush.
REQ-017 in_ready SHALL equal (count != DEPTH); no combinational path from out_ready to in_ready.
REQ-018 out_valid SHALL equal (count != 0); out_pc/out_inst SHALL be the head entry, read combinationally from storage.
REQ-019 Push-to-out_valid latency SHALL be exactly 1 cycle into an empty queue; no same-cycle bypass.
REQ-020 Simultaneous push and pop SHALL leave count unchanged; allowed at any occupancy 1..DEPTH-1; at DEPTH only pop occurs.
REQ-021 Pop with count==0 and push with count==DEPTH SHALL be ignored; no state change, no pointer movement.
REQ-022 Read and write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; occupancy tracked by count, not pointer compare.
REQ-023 flush SHALL have priority over push and pop: next cycle count=0, pointers=0, out_valid=0; entry on in_* during flush dropped.
REQ-024 When out_valid=1 and out_ready=0, out_pc/out_inst SHALL stay stable until popped or flushed.
REQ-025 Entries SHALL leave in strict push order; storage contents beyond count are don't-care but out_* SHALL be 0 when empty.

Reset
REQ-026 On rst, next edge: count=0, both pointers=0, out_valid=0, in_ready=1, out_pc=0, out_inst=0.
REQ-027 rst SHALL override flush, push and pop; reset mid-operation discards all entries.
REQ-028 Storage array SHALL NOT require reset; only control state is reset.

Structure
REQ-029 Default DEPTH and entry width (PC_W+INST_W) SHALL be defined in lib/defines.vh alongside IF_TO_ID_WD; entry width SHALL equal IF_TO_ID_WD minus the ce bit.
REQ-030 Storage, pointers and count SHALL be inline; no sub-module.
REQ-031 Block SHALL replace the single IF/ID pipeline register; flush driven by branch-taken from br_bus, out_ready driven by ~stall toward ID.

Verification
REQ-032 Reset then push PC 0xBFC00000/inst 0x3C011234 -> next cycle out_valid=1, out_pc=0xBFC00000, out_inst=0x3C011234, count=1.
REQ-033 DEPTH=4, push 5 consecutive with out_ready=0 -> in_ready=0 after 4th, 5th dropped, count=4; then pop 4 -> PCs in order, count=0.
REQ-034 count=2, simultaneous push and pop for 10 cycles -> count stays 2, pointers wrap, order preserved.
REQ-035 count=3 with flush=1 and in_valid=1 same cycle -> next cycle count=0, out_valid=0, out_pc=0; pushed entry absent.
REQ-036 out_ready=0 for 3 cycles with count=1 -> out_pc/out_inst unchanged; rst mid-hold -> count=0, out_valid=0 next cycle.
